fpu_issue_seq: RTL and testbench
================================

Name: fpu_issue_seq

Overview:
- Front-end sequencer for the FP16 FMA pipeline (fpu1 -> fpu2 -> fpu3).
- Accepts operand requests over a valid/ready handshake and drives fpu1 inputs from registers.
- Tracks the fixed 2-cycle pipeline latency with a valid/tag shift pipe and captures fpu3's combinational result exd into a result FIFO.
- Issue is credit-gated so every in-flight result always has a FIFO slot; the fixed-latency pipe never stalls.

Parameters:
- DEPTH, 4, result FIFO entries; power of two, minimum 2.
- TAG_W, 4, width of the request tag carried alongside each operation.

Ports:
- ACLK  in  1  clock.
- RSTN  in  1  async active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when both high.
- req_op  in  2  operation code, 0 = FMA.
- req_a  in  16  FP16 multiplicand.
- req_b  in  16  FP16 multiplier.
- req_c  in  16  FP16 addend.
- req_tag  in  TAG_W  tag returned with the result.
- op  out  2  to fpu1.op.
- ex1  out  16  to fpu1.ex1.
- ex2  out  16  to fpu1.ex2.
- ex3  out  16  to fpu1.ex3.
- exd  in  16  from fpu3.f.
- rsp_valid  out  1  FIFO head valid.
- rsp_ready  in  1  consumer takes head when both high.
- rsp_data  out  16  result (ex1*ex2+ex3 for FMA).
- rsp_tag  out  TAG_W  tag of head.
- busy  out  1  any operation in flight or FIFO non-empty.

Behaviour:
- Clock and reset: one clock, ACLK. Reset RSTN is asynchronous, active-low. All state is cleared immediately on RSTN low, mid-operation included. In-flight operations are discarded and never appear on rsp.
- Reset values: req_ready=0, op=0, ex1=ex2=ex3=0, rsp_valid=0, rsp_data=0, rsp_tag=0, busy=0. req_ready rises in the first cycle after RSTN deasserts.
- Issue (cycle T): on req_valid&&req_ready at an ACLK edge:
  - op/ex1/ex2/ex3 register the request fields and hold them for the following cycle, T+1.
  - v0 <= 1; tag0 <= req_tag.
  - Cycles with no issue set v0 <= 0. ex1..ex3 retain their last values; there is no bubble-zeroing.
- Pipe: v1 <= v0; tag1 <= tag0. A v0 op reaches fpu2 registers at the next edge. exd for an op driven during cycle X is valid during cycle X+2.
- Capture: three valid stages: v0 (driving fpu1), v1 (in fpu2 regs), v2 (in fpu3, exd valid). When v2=1, {exd, tag2} is written to the FIFO tail at the next edge.
- Issue-to-response latency: accepted at edge E, rsp_valid is asserted no earlier than the cycle after edge E+3 when the FIFO was empty. Back-to-back issue gives one result per cycle.
- Credit rule:
  - inflight = v0+v1+v2.
  - req_ready = (count + inflight < DEPTH), computed combinationally from registered state only; there is no combinational path from req_valid or rsp_ready.
  - A pop in the same cycle does not release credit until the next cycle.
- FIFO:
  - Circular buffer with rd/wr pointers of log2(DEPTH) bits; wrap modulo DEPTH; count ranges 0..DEPTH.
  - Simultaneous push and pop leaves count unchanged.
  - Pop on empty is impossible because rsp_valid=0.
  - Push on full is impossible by the credit rule. The verifier asserts that this never occurs.
- Response: rsp_data/rsp_tag are the FIFO head, registered-storage driven, and stable while rsp_valid&&!rsp_ready.
- req_op values other than 0 pass through unchanged to op. Their latency and credit handling are identical to FMA.
- busy = |{v0,v1,v2} || count!=0.

Optional Feature:
- FPU_ISSUE_FLAGS_EN defined:
  - Adds output rsp_flags[2:0] = {nan, inf, zero}, decoded from the stored result when it enters the FIFO.
  - nan: exp=1F and frac!=0. inf: exp=1F and frac=0. zero: exp=0 and frac=0.
  - The flags are stored per entry, so the FIFO width grows by 3.
  - Reset value 0.
- FPU_ISSUE_FLAGS_EN undefined: the port and storage are absent; behaviour is otherwise identical.

Test Plan:
- Reset then single FMA: a=3C00, b=4000, c=3C00, tag=1 -> rsp_valid in the cycle after edge E+3, rsp_data=4200, rsp_tag=1; busy returns to 0 after the pop.
- Back-to-back: 6 requests, rsp_ready=1, tags 0..5, a=3C00, b=3C00, c=0000 -> six consecutive rsp cycles, all data 3C00, tags in order 0..5.
- Backpressure: rsp_ready=0, req_valid held -> exactly DEPTH (4) accepts, then req_ready=0. Raising rsp_ready drains in order, and req_ready reasserts one cycle after the first pop.
- Simultaneous push/pop at count=DEPTH-1 with in-flight ops -> no overflow and no loss; count stays constant; all tags return in order.
- Async reset asserted mid-flight (2 ops in pipe, 2 in FIFO) -> all outputs drop to reset values immediately; no stale response after RSTN release.
- With FPU_ISSUE_FLAGS_EN: 7C00*3C00+0000 -> rsp_data=7C00, flags=010; 0000*0000+0000 -> rsp_data=0000, flags=001.

Source files
------------

// File: rtl/fpu_issue_seq.sv
// Issue sequencer for the FP16 FMA pipeline. Results come back with a fixed latency into a credit-protected FIFO.
// Optional build macro FPU_ISSUE_FLAGS_EN adds per-entry {nan, inf, zero} result flags on rsp_flags.
module fpu_issue_seq #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             ACLK,
    input  logic             RSTN,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [15:0]      req_a,
    input  logic [15:0]      req_b,
    input  logic [15:0]      req_c,
    input  logic [TAG_W-1:0] req_tag,
    output logic [1:0]       op,
    output logic [15:0]      ex1,
    output logic [15:0]      ex2,
    output logic [15:0]      ex3,
    input  logic [15:0]      exd,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [15:0]      rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
`ifdef FPU_ISSUE_FLAGS_EN
    output logic [2:0]       rsp_flags,
`endif
    output logic             busy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int UW = CW + 1;
`ifdef FPU_ISSUE_FLAGS_EN
    localparam int EW = TAG_W + 19;

    function automatic logic [2:0] fp16_flags(input logic [15:0] f);
        logic exp_max, exp_zero, frac_zero;
        exp_max   = &f[14:10];
        exp_zero  = ~|f[14:10];
        frac_zero = ~|f[9:0];
        return {exp_max & ~frac_zero, exp_max & frac_zero, exp_zero & frac_zero};
    endfunction
`else
    localparam int EW = TAG_W + 16;
`endif

    logic [EW-1:0]    mem [DEPTH];
    logic [EW-1:0]    entry;
    logic [EW-1:0]    head;
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [CW-1:0]    count;
    logic [UW-1:0]    used;
    logic             v0, v1, v2;
    logic [TAG_W-1:0] tag0, tag1, tag2;
    logic             started;
    logic             issue, push, pop;

    // Credit covers FIFO occupancy plus every op still in the fixed-latency pipe.
    assign used      = UW'(count) + UW'(v0) + UW'(v1) + UW'(v2);
    assign req_ready = started && (used < UW'(DEPTH));
    assign issue     = req_valid && req_ready;
    assign push      = v2;
    assign rsp_valid = (count != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign busy      = v0 || v1 || v2 || (count != '0);

`ifdef FPU_ISSUE_FLAGS_EN
    assign entry     = {fp16_flags(exd), exd, tag2};
    assign rsp_flags = rsp_valid ? head[TAG_W+16 +: 3] : '0;
`else
    assign entry     = {exd, tag2};
`endif
    assign head      = mem[rd_ptr];
    assign rsp_data  = rsp_valid ? head[TAG_W +: 16] : '0;
    assign rsp_tag   = rsp_valid ? head[TAG_W-1:0] : '0;

    always_ff @(posedge ACLK) begin
        if (push) mem[wr_ptr] <= entry;
    end

    always_ff @(posedge ACLK or negedge RSTN) begin
        if (!RSTN) begin
            started <= 1'b0;
            v0      <= 1'b0;
            v1      <= 1'b0;
            v2      <= 1'b0;
            tag0    <= '0;
            tag1    <= '0;
            tag2    <= '0;
            op      <= '0;
            ex1     <= '0;
            ex2     <= '0;
            ex3     <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
        end else begin
            started <= 1'b1;
            v0      <= issue;
            v1      <= v0;
            v2      <= v1;
            tag1    <= tag0;
            tag2    <= tag1;
            // Operands hold their last values between issues; fpu1 ignores them when v0 is low.
            if (issue) begin
                tag0 <= req_tag;
                op   <= req_op;
                ex1  <= req_a;
                ex2  <= req_b;
                ex3  <= req_c;
            end
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (!push && pop) count <= count - CW'(1);
        end
    end
endmodule

// File: tb/tb_fpu_issue_seq.sv
// Bench for fpu_issue_seq: stand-in 2-stage FPU, queue-based reference model, directed and random traffic.
module tb_fpu_issue_seq;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic             ACLK = 1'b0;
    logic             RSTN;
    logic             req_valid, req_ready, rsp_valid, rsp_ready, busy;
    logic [1:0]       req_op, op;
    logic [15:0]      req_a, req_b, req_c, ex1, ex2, ex3, exd, rsp_data;
    logic [TAG_W-1:0] req_tag, rsp_tag;
`ifdef FPU_ISSUE_FLAGS_EN
    logic [2:0]       rsp_flags;
`endif

    always #5 ACLK = ~ACLK;

    fpu_issue_seq #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .ACLK(ACLK), .RSTN(RSTN),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_tag(req_tag),
        .op(op), .ex1(ex1), .ex2(ex2), .ex3(ex3), .exd(exd),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_tag(rsp_tag),
`ifdef FPU_ISSUE_FLAGS_EN
        .rsp_flags(rsp_flags),
`endif
        .busy(busy)
    );

    // Stand-in FPU: exact results for the directed operand sets, a scrambling function otherwise.
    function automatic logic [15:0] fpu_stub(input logic [1:0] o, input logic [15:0] a, b, c);
        if (a == 16'h3C00 && b == 16'h4000 && c == 16'h3C00) return 16'h4200;
        if (b == 16'h3C00 && c == 16'h0000) return a;
        if (a == 16'h0000 && b == 16'h0000 && c == 16'h0000) return 16'h0000;
        return (a ^ {b[7:0], b[15:8]}) + c + {14'd0, o};
    endfunction

    function automatic logic [2:0] flags_of(input logic [15:0] d);
        int e, f;
        e = (d / 1024) % 32;
        f = d % 1024;
        return {e == 31 && f != 0, e == 31 && f == 0, e == 0 && f == 0};
    endfunction

    logic [15:0] p1, p2;
    always @(posedge ACLK) begin
        p1 <= fpu_stub(op, ex1, ex2, ex3);
        p2 <= p1;
    end
    assign exd = p2;

    typedef struct {
        logic [15:0]      data;
        logic [TAG_W-1:0] tag;
        int               due;
    } ent_t;

    ent_t        exp_q[$];
    int          cyc, acc_n, pop_n;
    bit          m_started;
    logic [1:0]  m_op;
    logic [15:0] m_a, m_b, m_c;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        acc_n = 0;
        pop_n = 0;
        m_started = 0;
        m_op = '0;
        m_a = '0;
        m_b = '0;
        m_c = '0;
    endtask

    task automatic check_reset();
        check_eq("rst_req_ready", req_ready, 0);
        check_eq("rst_op", op, 0);
        check_eq("rst_ex1", ex1, 0);
        check_eq("rst_ex2", ex2, 0);
        check_eq("rst_ex3", ex3, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_rsp_data", rsp_data, 0);
        check_eq("rst_rsp_tag", rsp_tag, 0);
        check_eq("rst_busy", busy, 0);
`ifdef FPU_ISSUE_FLAGS_EN
        check_eq("rst_rsp_flags", rsp_flags, 0);
`endif
    endtask

    task automatic check_outputs();
        bit want_v;
        int outstanding;
        outstanding = acc_n - pop_n;
        want_v = exp_q.size() > 0 && cyc >= exp_q[0].due;
        check_eq("req_ready", req_ready, m_started && outstanding < DEPTH);
        check_eq("busy", busy, outstanding != 0);
        check_eq("rsp_valid", rsp_valid, want_v);
        check_eq("op", op, m_op);
        check_eq("ex1", ex1, m_a);
        check_eq("ex2", ex2, m_b);
        check_eq("ex3", ex3, m_c);
        if (want_v && rsp_valid) begin
            check_eq("rsp_data", rsp_data, exp_q[0].data);
            check_eq("rsp_tag", rsp_tag, exp_q[0].tag);
`ifdef FPU_ISSUE_FLAGS_EN
            check_eq("rsp_flags", rsp_flags, flags_of(exp_q[0].data));
`endif
        end
    endtask

    // Called at a falling edge with inputs already driven; models the next rising edge, then checks.
    task automatic step();
        ent_t e;
        if (req_valid && req_ready) begin
            e.data = fpu_stub(req_op, req_a, req_b, req_c);
            e.tag  = req_tag;
            e.due  = cyc + 1 + 3;
            exp_q.push_back(e);
            m_op = req_op;
            m_a = req_a;
            m_b = req_b;
            m_c = req_c;
            acc_n++;
        end
        if (rsp_valid && rsp_ready && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            pop_n++;
        end
        cyc++;
        m_started = 1;
        @(negedge ACLK);
        check_outputs();
    endtask

    task automatic drive(input logic v, input logic [1:0] o, input logic [15:0] a, b, c,
                         input logic [TAG_W-1:0] t);
        req_valid = v;
        req_op = o;
        req_a = a;
        req_b = b;
        req_c = c;
        req_tag = t;
    endtask

    task automatic random_steps(input int n, input int pv, input int pr);
        for (int i = 0; i < n; i++) begin
            drive($urandom_range(99) < pv, 2'($urandom), 16'($urandom), 16'($urandom),
                  16'($urandom), TAG_W'($urandom));
            rsp_ready = $urandom_range(99) < pr;
            step();
        end
    endtask

    int base;

    initial begin
        RSTN = 1'b0;
        cyc = 0;
        rsp_ready = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (3) @(negedge ACLK);
        check_reset();
        RSTN = 1'b1;
        #1 check_outputs();

        // Single FMA: 1.0 * 2.0 + 1.0
        rsp_ready = 1'b1;
        drive(1, 0, 16'h3C00, 16'h4000, 16'h3C00, 4'd1);
        step();
        drive(0, 0, 0, 0, 0, 0);
        repeat (6) step();

        // Back-to-back issue, one result per cycle
        for (int t = 0; t < 6; t++) begin
            drive(1, 0, 16'h3C00, 16'h3C00, 16'h0000, TAG_W'(t));
            step();
        end
        drive(0, 0, 0, 0, 0, 0);
        repeat (8) step();

        // Backpressure: credit limits acceptance to DEPTH
        rsp_ready = 1'b0;
        base = acc_n;
        for (int t = 0; t < 10; t++) begin
            drive(1, 2'(t), 16'($urandom), 16'($urandom), 16'($urandom), TAG_W'(t + 3));
            step();
        end
        check_eq("bp_accepts", acc_n - base, DEPTH);
        drive(0, 0, 0, 0, 0, 0);
        rsp_ready = 1'b1;
        repeat (10) step();

        // Special results for the flag decode
        drive(1, 0, 16'h7C00, 16'h3C00, 16'h0000, 4'd9);
        step();
        drive(1, 0, 16'h0000, 16'h0000, 16'h0000, 4'd10);
        step();
        drive(1, 0, 16'h7E00, 16'h3C00, 16'h0000, 4'd11);
        step();
        drive(0, 0, 0, 0, 0, 0);
        repeat (6) step();

        // Mixed traffic, including push and pop in the same cycle near full
        random_steps(400, 70, 60);
        random_steps(200, 90, 85);
        drive(0, 0, 0, 0, 0, 0);
        rsp_ready = 1'b1;
        repeat (10) step();

        // Reset with two ops in the pipe and two results waiting in the FIFO
        rsp_ready = 1'b0;
        for (int t = 0; t < 4; t++) begin
            drive(1, 0, 16'($urandom), 16'($urandom), 16'($urandom), TAG_W'(t + 12));
            step();
        end
        drive(0, 0, 0, 0, 0, 0);
        step();
        check_eq("pre_rst_busy", busy, 1);
        RSTN = 1'b0;
        #1 check_reset();
        model_reset();
        repeat (2) @(negedge ACLK);
        check_reset();
        RSTN = 1'b1;
        #1 check_outputs();
        rsp_ready = 1'b1;
        repeat (6) step();
        random_steps(150, 60, 70);
        drive(0, 0, 0, 0, 0, 0);
        rsp_ready = 1'b1;
        repeat (10) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
